// File: rtl/param_div_counter.sv
// Prescaled up/down/ping-pong counter with a divided clock output and tick/terminal-count pulses.
// Define PARAM_DIV_COUNTER_SAT_EN to saturate (instead of wrap) in the up and down modes.
module param_div_counter #(
    parameter int WIDTH = 4,
    parameter int DIV   = 4
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count_out,
    output logic             clkout,
    output logic             tick,
    output logic             tc,
    output logic             dir
);

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_PING = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    localparam int             PW      = $clog2(DIV);
    localparam logic [PW-1:0]  P_LAST  = PW'(DIV - 1);
    localparam logic [PW-1:0]  P_ONE   = PW'(1);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [PW-1:0]    p;
    logic             step;
    logic [WIDTH-1:0] next_count;
    logic             next_dir;
    logic             next_tc;

    assign step = en && (p == P_LAST);

    // Count/direction/terminal-count result of a step, used only when step is high.
    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        next_count = count_out;
        next_dir   = dir;
        next_tc    = 1'b0;
        case (mode_e'(mode))
            MODE_UP: begin
                next_dir = 1'b1;
                if (count_out == CNT_MAX) begin
                    next_tc = 1'b1;
`ifdef PARAM_DIV_COUNTER_SAT_EN
                    next_count = CNT_MAX;
`else
                    next_count = '0;
`endif
                end else begin
                    next_count = count_out + CNT_ONE;
                end
            end
            MODE_DOWN: begin
                next_dir = 1'b0;
                if (count_out == '0) begin
                    next_tc = 1'b1;
`ifdef PARAM_DIV_COUNTER_SAT_EN
                    next_count = '0;
`else
                    next_count = CNT_MAX;
`endif
                end else begin
                    next_count = count_out - CNT_ONE;
                end
            end
            MODE_PING: begin
                if (dir) begin
                    if (count_out == CNT_MAX) begin
                        next_count = CNT_MAX - CNT_ONE;
                        next_dir   = 1'b0;
                        next_tc    = 1'b1;
                    end else begin
                        next_count = count_out + CNT_ONE;
                    end
                end else begin
                    if (count_out == '0) begin
                        next_count = CNT_ONE;
                        next_dir   = 1'b1;
                        next_tc    = 1'b1;
                    end else begin
                        next_count = count_out - CNT_ONE;
                    end
                end
            end
            MODE_HOLD: begin
                next_count = count_out;
            end
            default: begin
                next_count = count_out;
            end
        endcase
    end

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            p         <= '0;
            count_out <= '0;
            clkout    <= 1'b0;
            tick      <= 1'b0;
            tc        <= 1'b0;
            dir       <= 1'b1;
        end else begin
            tick <= step;
            tc   <= 1'b0;
            if (en) begin
                p <= (p == P_LAST) ? '0 : p + P_ONE;
            end
            if (step) begin
                clkout <= ~clkout;
            end
            // A load wins over a coincident step: no count change, no tc, direction kept.
            if (load) begin
                count_out <= load_val;
            end else if (step) begin
                count_out <= next_count;
                dir       <= next_dir;
                tc        <= next_tc;
            end
        end
    end

endmodule

// File: tb/tb_param_div_counter.sv
// Directed-vector bench for param_div_counter (WIDTH=4, DIV=4), plus reset and saturation sequences.
module tb_param_div_counter;

`ifdef PARAM_DIV_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] count_out;
    logic       clkout;
    logic       tick;
    logic       tc;
    logic       dir;

    int checks = 0;
    int errors = 0;

    param_div_counter #(.WIDTH(4), .DIV(4)) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .load      (load),
        .load_val  (load_val),
        .count_out (count_out),
        .clkout    (clkout),
        .tick      (tick),
        .tc        (tc),
        .dir       (dir)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic       ld;
        logic [3:0] ld_val;
        int         edges;
        logic [3:0] cnt;
        logic       tk;
        logic       tcx;
        logic       dr;
        logic       ck;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic e, input logic [1:0] m, input logic l, input logic [3:0] lv,
                       input int n, input logic [3:0] c, input logic tk, input logic tcx,
                       input logic dr, input logic ck);
        vec_t v;
        v.en = e; v.mode = m; v.ld = l; v.ld_val = lv; v.edges = n;
        v.cnt = c; v.tk = tk; v.tcx = tcx; v.dr = dr; v.ck = ck;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {count_out, tick, tc, dir, clkout};
    endfunction

    initial begin
        int n_edges;

        // en, mode, load, load_val, edges | count, tick, tc, dir, clkout
        add(1, 2'b00, 0,  0,  3,  0, 0, 0, 1, 0);
        add(1, 2'b00, 0,  0,  1,  1, 1, 0, 1, 1);
        add(1, 2'b00, 0,  0,  1,  1, 0, 0, 1, 1);
        add(1, 2'b00, 0,  0,  3,  2, 1, 0, 1, 0);
        add(1, 2'b00, 1, 15,  1, 15, 0, 0, 1, 0);
        add(1, 2'b00, 0,  0,  2, 15, 0, 0, 1, 0);
        add(1, 2'b00, 0,  0,  1, SAT ? 4'd15 : 4'd0, 1, 1, 1, 1);
        add(1, 2'b00, 1,  0,  1,  0, 0, 0, 1, 1);
        add(1, 2'b01, 0,  0,  2,  0, 0, 0, 1, 1);
        add(1, 2'b01, 0,  0,  1, SAT ? 4'd0 : 4'd15, 1, 1, 0, 0);
        add(1, 2'b01, 1, 15,  1, 15, 0, 0, 0, 0);
        add(1, 2'b01, 0,  0,  3, 14, 1, 0, 0, 1);
        add(1, 2'b00, 0,  0,  4, 15, 1, 0, 1, 0);
        add(1, 2'b10, 1, 14,  1, 14, 0, 0, 1, 0);
        add(1, 2'b10, 0,  0,  3, 15, 1, 0, 1, 1);
        add(1, 2'b10, 0,  0,  4, 14, 1, 1, 0, 0);
        add(1, 2'b10, 0,  0,  4, 13, 1, 0, 0, 1);
        add(1, 2'b10, 1,  1,  1,  1, 0, 0, 0, 1);
        add(1, 2'b10, 0,  0,  3,  0, 1, 0, 0, 0);
        add(1, 2'b10, 0,  0,  4,  1, 1, 1, 1, 1);
        add(1, 2'b01, 1,  0,  3,  0, 0, 0, 1, 1);
        add(1, 2'b01, 1,  9,  1,  9, 1, 0, 1, 0);
        add(0, 2'b00, 0,  0, 10,  9, 0, 0, 1, 0);
        add(1, 2'b00, 0,  0,  3,  9, 0, 0, 1, 0);
        add(1, 2'b00, 0,  0,  1, 10, 1, 0, 1, 1);
        add(1, 2'b11, 0,  0,  4, 10, 1, 0, 1, 0);
        add(1, 2'b11, 1, 15,  1, 15, 0, 0, 1, 0);
        add(1, 2'b11, 0,  0,  3, 15, 1, 0, 1, 1);

        rst_n = 1'b0; en = 1'b0; mode = 2'b00; load = 1'b0; load_val = '0;
        repeat (2) @(posedge clk_in);
        #1;
        check("reset_state", outs(), {4'd0, 1'b0, 1'b0, 1'b1, 1'b0});
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            en = vecs[i].en; mode = vecs[i].mode; load = vecs[i].ld; load_val = vecs[i].ld_val;
            repeat (vecs[i].edges) @(posedge clk_in);
            #1;
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].cnt, vecs[i].tk, vecs[i].tcx, vecs[i].dr, vecs[i].ck});
        end

        // Up mode at the limit: wrap (default) or saturate with tc on every step.
        en = 1'b1; mode = 2'b00; load = 1'b0;
        repeat (4) @(posedge clk_in);
        #1;
        check("limit_step1_count", count_out, SAT ? 32'd15 : 32'd0);
        check("limit_step1_tc", tc, 1);
        repeat (4) @(posedge clk_in);
        #1;
        check("limit_step2_count", count_out, SAT ? 32'd15 : 32'd1);
        check("limit_step2_tc", tc, SAT ? 32'd1 : 32'd0);

        // Reset asserted mid-count at count_out=7, p=2.
        load = 1'b1; load_val = 4'd7;
        repeat (2) @(posedge clk_in);
        #1;
        load = 1'b0;
        check("pre_reset_count", count_out, 7);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outs", outs(), {4'd0, 1'b0, 1'b0, 1'b1, 1'b0});
        #2 rst_n = 1'b1;
        n_edges = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk_in);
            #1;
            n_edges++;
            if (tick) break;
        end
        check("post_reset_tick_edge", n_edges, 4);
        check("post_reset_outs", outs(), {4'd1, 1'b1, 1'b0, 1'b1, 1'b1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
